// File: rtl/i2c_codec_responder.sv
`default_nettype none
// ============================================================================
// Module   : i2c_codec_responder
// Brief    : Write-only I2C target emulating the codec control port; decodes
//            3-byte writes into a 9-bit register file with ACK/NACK handling.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         NUM_REGS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i2c_sclk,
    input  logic       i2c_sdat_in,
    output logic       i2c_sdat_oe,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ACK1      = 3'd2,
        REGB      = 3'd3,
        ACK2      = 3'd4,
        DATB      = 3'd5,
        ACK3      = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    localparam logic [7:0] c_wr_byte   = {DEV_ADDR, 1'b0};
    localparam logic [7:0] c_store_lim = (NUM_REGS < 16) ? 8'(NUM_REGS) : 8'd16;
    localparam logic [6:0] c_reset_reg = 7'h0F;

    state_t      r_state, w_state_nx;
    logic [2:0]  r_scl_sync, r_sda_sync;
    logic [3:0]  r_cnt, w_cnt_nx;
    logic [7:0]  r_shift, w_shift_nx;
    logic [6:0]  r_addr;
    logic        r_d8;
    logic        r_oe, w_oe_nx;
    logic        r_busy, w_busy_nx;
    logic        r_err, w_err_nx;
    logic        r_wr_valid;
    logic [6:0]  r_wr_addr;
    logic [8:0]  r_wr_data;
    logic [8:0]  r_regs [16];
    logic        w_latch_reg, w_commit;
    logic        w_scl_rise, w_scl_fall, w_start, w_stop;

    // Stage 2 is the settled level, stage 3 the previous one for edge detection.
    assign w_scl_rise = r_scl_sync[1] & ~r_scl_sync[2];
    assign w_scl_fall = ~r_scl_sync[1] & r_scl_sync[2];
    assign w_start    = r_scl_sync[1] & r_scl_sync[2] & ~r_sda_sync[1] & r_sda_sync[2];
    assign w_stop     = r_scl_sync[1] & r_scl_sync[2] & r_sda_sync[1] & ~r_sda_sync[2];

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_shift_nx  = r_shift;
        w_oe_nx     = r_oe;
        w_busy_nx   = r_busy;
        w_err_nx    = 1'b0;
        w_latch_reg = 1'b0;
        w_commit    = 1'b0;
        if (w_start) begin
            w_state_nx = ADDR;
            w_cnt_nx   = 4'd0;
            w_busy_nx  = 1'b1;
            w_oe_nx    = 1'b0;
        end else if (w_stop) begin
            w_state_nx = IDLE;
            w_cnt_nx   = 4'd0;
            w_busy_nx  = 1'b0;
            w_oe_nx    = 1'b0;
        end else if (w_scl_rise) begin
            if ((r_state == ADDR || r_state == REGB || r_state == DATB) && r_cnt < 4'd8) begin
                w_shift_nx = {r_shift[6:0], r_sda_sync[1]};
                w_cnt_nx   = r_cnt + 4'd1;
            end
        end else if (w_scl_fall) begin
            case (r_state)
                ADDR: if (r_cnt == 4'd8) begin
                    w_cnt_nx = 4'd0;
                    if (r_shift == c_wr_byte) begin
                        w_state_nx = ACK1;
                        w_oe_nx    = 1'b1;
                    end else begin
                        w_state_nx = WAIT_STOP;
                        w_err_nx   = 1'b1;
                    end
                end
                ACK1: begin
                    w_state_nx = REGB;
                    w_oe_nx    = 1'b0;
                end
                REGB: if (r_cnt == 4'd8) begin
                    w_cnt_nx    = 4'd0;
                    w_latch_reg = 1'b1;
                    w_state_nx  = ACK2;
                    w_oe_nx     = 1'b1;
                end
                ACK2: begin
                    w_state_nx = DATB;
                    w_oe_nx    = 1'b0;
                end
                DATB: if (r_cnt == 4'd8) begin
                    w_cnt_nx   = 4'd0;
                    w_commit   = 1'b1;
                    w_state_nx = ACK3;
                    w_oe_nx    = 1'b1;
                end
                ACK3: begin
                    w_state_nx = WAIT_STOP;
                    w_oe_nx    = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_scl_sync <= 3'b111;
            r_sda_sync <= 3'b111;
            r_cnt      <= 4'd0;
            r_shift    <= 8'd0;
            r_addr     <= 7'd0;
            r_d8       <= 1'b0;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 7'd0;
            r_wr_data  <= 9'd0;
            for (int i = 0; i < 16; i++) r_regs[i] <= 9'd0;
        end else begin
            r_state    <= w_state_nx;
            r_scl_sync <= {r_scl_sync[1:0], i2c_sclk};
            r_sda_sync <= {r_sda_sync[1:0], i2c_sdat_in};
            r_cnt      <= w_cnt_nx;
            r_shift    <= w_shift_nx;
            r_oe       <= w_oe_nx;
            r_busy     <= w_busy_nx;
            r_err      <= w_err_nx;
            r_wr_valid <= w_commit;
            if (w_latch_reg) begin
                r_addr <= r_shift[7:1];
                r_d8   <= r_shift[0];
            end
            if (w_commit) begin
                r_wr_addr <= r_addr;
                r_wr_data <= {r_d8, r_shift};
                // Writing the codec reset register wipes the whole file.
                if (r_addr == c_reset_reg) begin
                    for (int i = 0; i < 16; i++) r_regs[i] <= 9'd0;
                end else if ({1'b0, r_addr} < c_store_lim) begin
                    r_regs[r_addr[3:0]] <= {r_d8, r_shift};
                end
            end
        end
    end

    assign i2c_sdat_oe = r_oe;
    assign busy        = r_busy;
    assign err         = r_err;
    assign wr_valid    = r_wr_valid;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign rd_data     = r_regs[rd_addr];

endmodule
`default_nettype wire

// File: tb/tb_i2c_codec_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_codec_responder
// Brief    : Directed plus randomized I2C write bench with a register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_codec_responder;

    localparam int Q = 5;   // system clocks per SCL quarter period

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       scl   = 1'b1;
    logic       m_sda = 1'b1;
    logic       oe;
    logic [3:0] rd_addr = 4'd0;
    logic [8:0] rd_data;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;
    logic       err;
    wire        sda_pin = m_sda & ~oe;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_valid  = 0;
    int         n_errp   = 0;
    logic [6:0] last_a   = '0;
    logic [8:0] last_d   = '0;
    logic [8:0] model [16];

    i2c_codec_responder #(.DEV_ADDR(7'h1A), .NUM_REGS(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .i2c_sclk    (scl),
        .i2c_sdat_in (sda_pin),
        .i2c_sdat_oe (oe),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .err         (err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            if (wr_valid) begin
                n_valid <= n_valid + 1;
                last_a  <= wr_addr;
                last_d  <= wr_data;
            end
            if (err) n_errp <= n_errp + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; tick(Q);
        scl   = 1'b1; tick(2 * Q);
        scl   = 1'b0; tick(Q);
    endtask

    // Eight data bits then the 9th clock, returning whether SDA was held low.
    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        ack   = (sda_pin == 1'b0);
        tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    // Reference behaviour of a committed write: store, ignore or clear.
    task automatic model_write(input logic [7:0] r, input logic [7:0] d);
        int a = int'(r[7:1]);
        if (a == 15) begin
            for (int i = 0; i < 16; i++) model[i] = 9'd0;
        end else if (a < 16) begin
            model[a] = {r[0], d};
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            tick(1);
            check(tag, 32'(rd_data), 32'(model[i]));
        end
    endtask

    task automatic do_write(input logic [7:0] dev, input logic [7:0] r, input logic [7:0] d,
                            input string tag);
        int   v0 = n_valid;
        int   e0 = n_errp;
        logic match = (dev == 8'h34);
        logic a1, a2, a3;
        i2c_start();
        check({tag, "_busy_hi"}, 32'(busy), 32'(1));
        send_byte(dev, a1);
        send_byte(r, a2);
        send_byte(d, a3);
        i2c_stop();
        tick(Q);
        check({tag, "_busy_lo"}, 32'(busy), 32'(0));
        check({tag, "_ack1"}, 32'(a1), 32'(match));
        check({tag, "_ack2"}, 32'(a2), 32'(match));
        check({tag, "_ack3"}, 32'(a3), 32'(match));
        check({tag, "_nvalid"}, 32'(n_valid - v0), 32'(match));
        check({tag, "_nerr"}, 32'(n_errp - e0), 32'(!match));
        if (match) begin
            check({tag, "_wr_addr"}, 32'(last_a), 32'(r[7:1]));
            check({tag, "_wr_data"}, 32'(last_d), 32'({r[0], d}));
            model_write(r, d);
        end
        check_regs({tag, "_regs"});
    endtask

    initial begin
        logic a;
        int   v0;
        for (int i = 0; i < 16; i++) model[i] = 9'd0;
        tick(4);
        check("rst_oe", 32'(oe), 32'(0));
        check("rst_wr_valid", 32'(wr_valid), 32'(0));
        check("rst_wr_addr", 32'(wr_addr), 32'(0));
        check("rst_wr_data", 32'(wr_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        reset = 1'b0;
        tick(4);
        check_regs("rst_regs");

        do_write(8'h34, 8'h0C, 8'h00, "w_06");
        do_write(8'h34, 8'h05, 8'h7B, "w_02");
        do_write(8'h30, 8'h0C, 8'h00, "bad_dev");
        do_write(8'h35, 8'h04, 8'h11, "read_req");

        // STOP in the middle of the data byte discards it.
        v0 = n_valid;
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h0E, a);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_stop();
        tick(Q);
        check("midstop_nvalid", 32'(n_valid - v0), 32'(0));
        check("midstop_busy", 32'(busy), 32'(0));
        do_write(8'h34, 8'h0E, 8'h42, "w_07");

        do_write(8'h34, 8'h04, 8'hA5, "pre_2");
        do_write(8'h34, 8'h0D, 8'h3C, "pre_6");
        do_write(8'h34, 8'h1E, 8'h00, "clr");
        do_write(8'h34, 8'h40, 8'h99, "hi_addr");

        // Reset while the responder holds the second ACK.
        do_write(8'h34, 8'h07, 8'h21, "pre_rst");
        i2c_start();
        send_byte(8'h34, a);
        for (int i = 7; i >= 0; i--) send_bit(i == 2);
        m_sda = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        check("ack2_oe", 32'(oe), 32'(1));
        reset = 1'b1;
        tick(1);
        check("rst_mid_oe", 32'(oe), 32'(0));
        check("rst_mid_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 9'd0;
        tick(2 * Q);
        check_regs("rst_mid_regs");
        do_write(8'h34, 8'h09, 8'h5A, "post_rst");

        // Repeated START after the register byte restarts without committing.
        v0 = n_valid;
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h08, a);
        i2c_start();
        check("rs_busy", 32'(busy), 32'(1));
        send_byte(8'h34, a);
        send_byte(8'h0A, a);
        send_byte(8'h55, a);
        i2c_stop();
        tick(Q);
        check("rs_nvalid", 32'(n_valid - v0), 32'(1));
        check("rs_wr_addr", 32'(last_a), 32'(7'h05));
        check("rs_wr_data", 32'(last_d), 32'(9'h055));
        model_write(8'h0A, 8'h55);
        check_regs("rs_regs");

        for (int t = 0; t < 25; t++) begin
            logic [7:0] dv, rg, dt;
            dv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34;
            rg = 8'($urandom_range(0, 47));
            dt = 8'($urandom);
            do_write(dv, rg, dt, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
